// File: rtl/bp_me_mem_cmd_arbiter.sv
// bp_me_mem_cmd_arbiter: round-robin wormhole arbiter merging requester flit streams onto one memory command link
module bp_me_mem_cmd_arbiter #(
  parameter int num_req_p = 4,
  parameter int flit_width_p = 64,
  parameter int len_width_p = 4,
  localparam int id_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic [num_req_p-1:0]              req_v_i,
  input  logic [num_req_p*flit_width_p-1:0] req_data_i,
  output logic [num_req_p-1:0]              req_ready_o,
  output logic                              link_v_o,
  output logic [flit_width_p-1:0]           link_data_o,
  input  logic                              link_ready_i,
  output logic [id_width_lp-1:0]            grant_id_o
);
  typedef enum logic {IDLE, BUSY} state_e;
  state_e state_q, state_n;
  logic [id_width_lp-1:0] rr_q, rr_n, lock_q, lock_n, rr_sel, idx, sel;
  logic [len_width_p-1:0] cnt_q, cnt_n, len;
  logic found, xfer;
  assign sel = (state_q == BUSY) ? lock_q : rr_sel;
  assign link_v_o = reset_n_i & req_v_i[sel];
  assign link_data_o = req_data_i[sel*flit_width_p +: flit_width_p];
  assign grant_id_o = sel;
  assign xfer = link_v_o & link_ready_i;
  assign len = link_data_o[len_width_p-1:0];
  // first valid requester at or after rr_q, wrapping
  always_comb begin
    rr_sel = rr_q;
    idx = '0;
    found = 1'b0;
    for (int i = 0; i < num_req_p; i++) begin
      idx = id_width_lp'((int'(rr_q) + i) % num_req_p);
      if (!found && req_v_i[idx]) begin
        found = 1'b1;
        rr_sel = idx;
      end
    end
  end
  // only the selected requester sees the link's ready, and only when it is actually transferring
  always_comb begin
    req_ready_o = '0;
    req_ready_o[sel] = xfer;
  end
  // header transfers lock the winner for its body flits; the last body flit releases the lock
  always_comb begin
    state_n = state_q;
    rr_n = rr_q;
    lock_n = lock_q;
    cnt_n = cnt_q;
    if (xfer && state_q == IDLE) begin
      rr_n = (rr_sel == id_width_lp'(num_req_p - 1)) ? '0 : rr_sel + 1'b1;
      lock_n = rr_sel;
      cnt_n = len;
      state_n = (len != '0) ? BUSY : IDLE;
    end else if (xfer) begin
      cnt_n = cnt_q - 1'b1;
      state_n = (cnt_q == len_width_p'(1)) ? IDLE : BUSY;
    end
  end
  // state register; reset abandons any packet in flight
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      rr_q <= '0;
      lock_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_n;
      rr_q <= rr_n;
      lock_q <= lock_n;
      cnt_q <= cnt_n;
    end
  end
endmodule

// File: tb/tb_bp_me_mem_cmd_arbiter.sv
// tb_bp_me_mem_cmd_arbiter: directed and randomized checks of the memory command arbiter
module tb_bp_me_mem_cmd_arbiter;
  localparam int N = 4;
  localparam int W = 16;
  localparam int L = 4;
  logic clk = 1'b0;
  logic reset_n_i;
  logic [N-1:0] req_v;
  logic [N*W-1:0] req_data;
  logic [N-1:0] req_ready;
  logic link_v;
  logic [W-1:0] link_data;
  logic link_ready;
  logic [1:0] grant_id;
  int tests = 0;
  int fails = 0;
  bp_me_mem_cmd_arbiter #(.num_req_p(N), .flit_width_p(W), .len_width_p(L)) dut (
    .clk_i(clk),
    .reset_n_i(reset_n_i),
    .req_v_i(req_v),
    .req_data_i(req_data),
    .req_ready_o(req_ready),
    .link_v_o(link_v),
    .link_data_o(link_data),
    .link_ready_i(link_ready),
    .grant_id_o(grant_id)
  );
  always #10 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [W-1:0] hdr(input int len, input int tag);
    return {12'(tag), 4'(len)};
  endfunction
  logic [W-1:0] q[N][$];
  bit pres[N];
  int owner, remain, ptr, sel, plen, idx;
  initial begin
    reset_n_i = 1'b0;
    link_ready = 1'b1;
    req_v = '1;
    req_data = '0;
    for (int k = 0; k < N; k++) req_data[k*W +: W] = hdr(0, k);
    #1;
    chk("rst_link_v", link_v, 0);
    chk("rst_req_ready", req_ready, 0);
    @(negedge clk); reset_n_i = 1'b1; req_v = '0; #1;
    chk("idle_none_v", link_v, 0);
    chk("idle_none_ready", req_ready, 0);
    @(negedge clk); req_v = 4'b0100; req_data[2*W +: W] = hdr(0, 'h2a); #1;
    chk("single_v", link_v, 1);
    chk("single_grant", grant_id, 2);
    chk("single_ready", req_ready, 4'b0100);
    chk("single_data", link_data, hdr(0, 'h2a));
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); req_v = '1; #1;
      chk("fair_grant", grant_id, (3 + i) % 4);
      chk("fair_ready", req_ready, 4'b0001 << ((3 + i) % 4));
    end
    @(negedge clk); req_v = 4'b0001; #1;
    chk("lock_pre_grant", grant_id, 0);
    @(negedge clk); req_v = 4'b1011; req_data[1*W +: W] = hdr(3, 'h11); #1;
    chk("lock_hdr_grant", grant_id, 1);
    chk("lock_hdr_data", link_data, hdr(3, 'h11));
    for (int b = 1; b <= 3; b++) begin
      @(negedge clk); req_data[1*W +: W] = 16'hb000 + 16'(b); #1;
      chk("lock_body_grant", grant_id, 1);
      chk("lock_body_data", link_data, 16'hb000 + 16'(b));
      chk("lock_body_ready", req_ready, 4'b0010);
    end
    @(negedge clk); req_v = 4'b1001; link_ready = 1'b0; #1;
    chk("lock_after_no2", grant_id, 3);
    chk("lock_after_no2_ready", req_ready, 0);
    @(negedge clk); req_v = '1; link_ready = 1'b1; req_data[1*W +: W] = hdr(0, 1); #1;
    chk("lock_after_with2", grant_id, 2);
    @(negedge clk); req_data[3*W +: W] = hdr(2, 'h33); #1;
    chk("bp_hdr_grant", grant_id, 3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); link_ready = 1'b0; req_data[3*W +: W] = 16'hc001; #1;
      chk("bp_hold_v", link_v, 1);
      chk("bp_hold_grant", grant_id, 3);
      chk("bp_hold_data", link_data, 16'hc001);
      chk("bp_hold_ready", req_ready, 0);
    end
    @(negedge clk); link_ready = 1'b1; #1;
    chk("bp_body1_grant", grant_id, 3);
    chk("bp_body1_ready", req_ready, 4'b1000);
    @(negedge clk); req_data[3*W +: W] = 16'hc002; #1;
    chk("bp_body2_grant", grant_id, 3);
    chk("bp_body2_data", link_data, 16'hc002);
    @(negedge clk); req_data[3*W +: W] = hdr(0, 3); #1;
    chk("bp_next_grant", grant_id, 0);
    @(negedge clk); req_data[1*W +: W] = hdr(2, 'h34); #1;
    chk("bub_hdr_grant", grant_id, 1);
    @(negedge clk); req_data[1*W +: W] = 16'hd001; #1;
    chk("bub_body1_data", link_data, 16'hd001);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); req_v = 4'b1101; #1;
      chk("bub_v", link_v, 0);
      chk("bub_other_ready", req_ready & 4'b1101, 0);
    end
    @(negedge clk); req_v = '1; req_data[1*W +: W] = 16'hd002; #1;
    chk("bub_body2_grant", grant_id, 1);
    chk("bub_body2_data", link_data, 16'hd002);
    @(negedge clk); req_data[1*W +: W] = hdr(0, 1); link_ready = 1'b0; #1;
    chk("bub_next_grant", grant_id, 2);
    @(negedge clk); link_ready = 1'b1; req_data[2*W +: W] = hdr(2, 'h35); #1;
    chk("ar_hdr_grant", grant_id, 2);
    @(negedge clk); req_data[2*W +: W] = 16'he001; link_ready = 1'b0; #1;
    chk("ar_busy_grant", grant_id, 2);
    #1 reset_n_i = 1'b0;
    #1;
    chk("ar_rst_v", link_v, 0);
    chk("ar_rst_ready", req_ready, 0);
    #1 reset_n_i = 1'b1; link_ready = 1'b1; req_v = 4'b1011; req_data[2*W +: W] = hdr(0, 2);
    #1;
    chk("ar_post_grant", grant_id, 0);
    chk("ar_post_v", link_v, 1);
    @(negedge clk); reset_n_i = 1'b0; req_v = '0;
    @(negedge clk); reset_n_i = 1'b1;
    owner = -1;
    remain = 0;
    ptr = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        if (q[k].size() == 0 && $urandom_range(0, 2) == 0) begin
          plen = ($urandom_range(0, 4) == 0) ? 15 : int'($urandom_range(0, 3));
          q[k].push_back(hdr(plen, int'($urandom)));
          for (int b = 0; b < plen; b++) q[k].push_back(W'($urandom));
        end
        if (!pres[k] && q[k].size() > 0 && $urandom_range(0, 3) != 0) pres[k] = 1'b1;
        req_v[k] = pres[k];
        req_data[k*W +: W] = pres[k] ? q[k][0] : W'($urandom);
      end
      link_ready = ($urandom_range(0, 3) != 0);
      sel = -1;
      if (owner >= 0) sel = pres[owner] ? owner : -1;
      else for (int i = 0; i < N; i++) begin
        idx = (ptr + i) % N;
        if (sel < 0 && pres[idx]) sel = idx;
      end
      #1;
      if (sel >= 0) begin
        chk("rnd_v", link_v, 1);
        chk("rnd_grant", grant_id, sel);
        chk("rnd_data", link_data, q[sel][0]);
        chk("rnd_ready", req_ready, link_ready ? (4'b0001 << sel) : 4'b0000);
        if (link_ready) begin
          if (owner < 0) begin
            ptr = (sel + 1) % N;
            remain = int'(q[sel][0][L-1:0]);
            owner = (remain > 0) ? sel : -1;
          end else begin
            remain--;
            if (remain == 0) owner = -1;
          end
          void'(q[sel].pop_front());
          pres[sel] = 1'b0;
        end
      end else begin
        chk("rnd_idle_v", link_v, 0);
        if (owner < 0) chk("rnd_idle_ready", req_ready, 0);
        else chk("rnd_bubble_ready", req_ready & ~(4'b0001 << owner), 0);
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
